// File: rtl/fprti_div_arbiter.sv
// Round-robin arbiter sharing one FP32 divider among NUM_REQ requesters.
// Tracks in-flight requester IDs in issue order and tags each quotient on return.
module fprti_div_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0][31:0]  req_dividend_i,
  input  logic [NUM_REQ-1:0][31:0]  req_divisor_i,
  output logic                      div_in_valid_o,
  input  logic                      div_in_ready_i,
  output logic [31:0]               div_op_a_o,
  output logic [31:0]               div_op_b_o,
  input  logic                      div_out_valid_i,
  input  logic [31:0]               div_result_i,
  output logic                      rsp_valid_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [31:0]               rsp_data_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_fifo_q [MAX_OUTST];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            any_valid;
  logic            can_issue;
  logic            issue;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    winner    = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!any_valid && req_valid_i[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // A full FIFO blocks issue even when a pop happens this cycle (no bypass).
  always_comb begin
    can_issue      = div_in_ready_i & (cnt_q < CntW'(MAX_OUTST));
    issue          = can_issue & any_valid & ~rst;
    div_in_valid_o = issue;
    req_ready_o    = issue ? (NUM_REQ'(1) << winner) : '0;
    div_op_a_o     = any_valid ? req_dividend_i[winner] : '0;
    div_op_b_o     = any_valid ? req_divisor_i[winner]  : '0;
    pop            = div_out_valid_i & (cnt_q != '0);
    cnt_d          = cnt_q + CntW'(issue) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (issue) begin
        id_fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
        rr_ptr_q            <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if (pop) begin
        rd_ptr_q    <= ptr_inc(rd_ptr_q);
        rsp_valid_o <= 1'b1;
        rsp_id_o    <= id_fifo_q[rd_ptr_q];
        rsp_data_o  <= div_result_i;
      end else begin
        rsp_valid_o <= 1'b0;
      end
      // A result with nothing in flight has no owner; flag it and drop it.
      if (div_out_valid_i && cnt_q == '0) begin
        err_o <= 1'b1;
      end
      cnt_q  <= cnt_d;
      busy_o <= (cnt_d != '0);
    end
  end

endmodule

// File: tb/tb_fprti_div_arbiter.sv
// Randomized scoreboard bench for fprti_div_arbiter with an in-order divider model
// and a round-robin reference model.
module tb_fprti_div_arbiter;

  localparam int NREQ = 4;
  localparam int MAXO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0]       req_ready;
  logic [3:0][31:0] dvd = '0;
  logic [3:0][31:0] dvs = '0;
  logic             div_in_valid;
  logic             div_in_ready = 1'b0;
  logic [31:0]      div_op_a, div_op_b;
  logic             div_out_valid = 1'b0;
  logic [31:0]      div_result = '0;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [31:0]      rsp_data;
  logic             busy, err;

  fprti_div_arbiter #(.NUM_REQ(NREQ), .MAX_OUTST(MAXO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_dividend_i  (dvd),
    .req_divisor_i   (dvs),
    .div_in_valid_o  (div_in_valid),
    .div_in_ready_i  (div_in_ready),
    .div_op_a_o      (div_op_a),
    .div_op_b_o      (div_op_b),
    .div_out_valid_i (div_out_valid),
    .div_result_i    (div_result),
    .rsp_valid_o     (rsp_valid),
    .rsp_id_o        (rsp_id),
    .rsp_data_o      (rsp_data),
    .busy_o          (busy),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] data; } exp_t;
  typedef struct { int due; logic [31:0] res; } pipe_t;

  exp_t  sb[$];
  pipe_t pipe[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    last_due = 0;
  int    lat = 3;
  bit    in_rdy_rand = 0;
  int    m_rr = 0;
  int    m_cnt = 0;
  bit    m_err = 0;
  bit    ret_exp = 0;
  bit [3:0]    pend = '0;
  logic [31:0] opa [4];
  logic [31:0] opb [4];
  int          last_id = -1;
  logic [31:0] last_data = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Stand-in for the divider: exact quotients for the directed operands, a fixed mix otherwise.
  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40E00000 && b == 32'h40000000) return 32'h40600000;
    if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]};
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rsp_valid || ret_exp) begin
      if (!ret_exp) begin
        chk("rsp_valid_unexpected", 32'(rsp_valid), 32'd0);
      end else if (sb.size() == 0) begin
        chk("rsp_scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", rsp_data, e.data);
        last_id   = int'(rsp_id);
        last_data = rsp_data;
      end
    end
  end

  task automatic refill(input int pct);
    for (int k = 0; k < NREQ; k++) begin
      if (!pend[k] && $urandom_range(0, 99) < pct) begin
        pend[k] = 1'b1;
        opa[k]  = $urandom;
        opb[k]  = $urandom;
      end
    end
  endtask

  task automatic step(input bit spur);
    int         win;
    bit         ret;
    logic [3:0] exp_rdy;
    pipe_t      p;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("err", 32'(err), 32'(m_err));
    req_valid = pend;
    for (int k = 0; k < NREQ; k++) begin
      dvd[k] = opa[k];
      dvs[k] = opb[k];
    end
    div_in_ready = in_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    ret = 1'b0;
    if (spur) begin
      div_out_valid = 1'b1;
      div_result    = $urandom;
      ret           = 1'b1;
    end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      p             = pipe.pop_front();
      div_out_valid = 1'b1;
      div_result    = p.res;
      ret           = 1'b1;
    end else begin
      div_out_valid = 1'b0;
      div_result    = $urandom;
    end
    #1;
    win = -1;
    if (div_in_ready && m_cnt < MAXO) begin
      for (int i = 0; i < NREQ; i++) begin
        if (win < 0 && pend[(m_rr + i) % NREQ]) win = (m_rr + i) % NREQ;
      end
    end
    exp_rdy = (win >= 0) ? 4'(1 << win) : 4'd0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("div_in_valid", 32'(div_in_valid), 32'(win >= 0));
    if (win >= 0) begin
      chk("div_op_a", div_op_a, opa[win]);
      chk("div_op_b", div_op_b, opb[win]);
      sb.push_back('{id: win, data: div_model(opa[win], opb[win])});
      p.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      p.res    = div_model(div_op_a, div_op_b);
      last_due = p.due;
      pipe.push_back(p);
      pend[win] = 1'b0;
      m_rr      = (win + 1) % NREQ;
    end else if (pend == 0) begin
      chk("div_op_a_idle", div_op_a, 32'd0);
    end
    ret_exp = ret && (m_cnt > 0);
    if (ret && m_cnt == 0) m_err = 1'b1;
    m_cnt = m_cnt + ((win >= 0) ? 1 : 0) - (ret_exp ? 1 : 0);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    req_valid     = 4'hF;
    div_in_ready  = 1'b1;
    div_out_valid = 1'b0;
    ret_exp       = 1'b0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_div_in_valid", 32'(div_in_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pend = '0;
    req_valid = '0;
    m_rr = 0;
    m_cnt = 0;
    m_err = 0;
    sb.delete();
    pipe.delete();
    cyc++;
    last_due = cyc;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
  endtask

  task automatic drain();
    pend = '0;
    for (int i = 0; i < 100 && (m_cnt != 0 || pipe.size() != 0); i++) step(1'b0);
    step(1'b0);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_scoreboard", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end
    do_reset();

    // Single request 7.0 / 2.0 from requester 0.
    lat = 3;
    pend[0] = 1'b1; opa[0] = 32'h40E00000; opb[0] = 32'h40000000;
    step(1'b0);
    drain();
    chk("single_id", 32'(last_id), 32'd0);
    chk("single_data", last_data, 32'h40600000);

    // Fairness with all requesters valid, then req1/req3 only after rr_ptr lands on 2.
    lat = 1;
    for (int i = 0; i < 10; i++) begin refill(100); step(1'b0); end
    drain();
    pend = 4'b0010; opa[1] = $urandom; opb[1] = $urandom;
    step(1'b0);
    pend = 4'b1010; opa[1] = $urandom; opb[1] = $urandom; opa[3] = $urandom; opb[3] = $urandom;
    step(1'b0);
    chk("rr_skip_to_3", 32'(pend), 32'b0010);
    drain();

    // Long divider latency: outstanding limit must throttle issue.
    lat = 10;
    for (int i = 0; i < 30; i++) begin refill(100); step(1'b0); end
    drain();

    // Issue and return in the same cycle with 1.0 / 4.0 traffic.
    lat = 2;
    for (int i = 0; i < 8; i++) begin
      if (!pend[i % NREQ]) begin
        pend[i % NREQ] = 1'b1; opa[i % NREQ] = 32'h3F800000; opb[i % NREQ] = 32'h40800000;
      end
      step(1'b0);
    end
    drain();
    chk("quarter_data", last_data, 32'h3E800000);

    // Spurious divider return with nothing in flight; err stays sticky.
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset with three divisions in flight, then a fresh request.
    lat = 10;
    pend = 4'b0111;
    for (int k = 0; k < 3; k++) begin opa[k] = $urandom; opb[k] = $urandom; end
    repeat (3) step(1'b0);
    chk("midflight_busy", 32'(busy), 32'd1);
    do_reset();
    lat = 2;
    pend[2] = 1'b1; opa[2] = 32'h40E00000; opb[2] = 32'h40000000;
    step(1'b0);
    drain();
    chk("post_reset_id", 32'(last_id), 32'd2);
    chk("post_reset_data", last_data, 32'h40600000);

    // Randomized traffic with back-pressure and varying latency.
    in_rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 6);
      refill(40);
      step(1'b0);
    end
    in_rdy_rand = 1'b0;
    drain();
    chk("final_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
